// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port RAM: picks a requester, then steps
// the RAM through its write-strobe / output-enable / data-drive sequence and acks.
module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_o,
  output logic              ram_oe,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wdrive,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_DATA, RESP} state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                pick;
  logic                pick_we;

  // Tie-break: round-robin favours the port not served last; fixed mode favours port 0.
  always_comb begin
    if (req0 && req1) pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    else              pick = req1 & ~req0;
    pick_we = pick ? we1 : we0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    ack0       = 1'b0;
    ack1       = 1'b0;
    ram_addr   = '0;
    ram_o      = 1'b0;
    ram_oe     = 1'b0;
    ram_wdata  = '0;
    ram_wdrive = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          last_d  = pick;
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          state_d = pick_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        ram_addr   = addr_q;
        ram_o      = 1'b1;
        ram_wdrive = 1'b1;
        ram_wdata  = wdata_q;
        state_d    = RESP;
      end
      RD_ADDR: begin
        ram_addr = addr_q;
        state_d  = RD_DATA;
      end
      RD_DATA: begin
        ram_addr = addr_q;
        ram_oe   = 1'b1;
        if (owner_q) rdata1_d = ram_rdata;
        else         rdata0_d = ram_rdata;
        state_d  = RESP;
      end
      RESP: begin
        ack0    = ~owner_q;
        ack1    = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ownership is visible for the whole access, including the ack cycle.
  always_comb begin
    gnt = 2'b00;
    if (state_q != IDLE) gnt = owner_q ? 2'b10 : 2'b01;
  end

  assign busy   = (state_q != IDLE);
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances share stimulus,
// each with its own RAM; results are predicted from a memory/pointer model.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;

  logic       ack0_a, ack1_a, busy_a, ram_o_a, ram_oe_a, ram_wdrive_a;
  logic [1:0] gnt_a;
  logic [7:0] rdata0_a, rdata1_a, ram_addr_a, ram_wdata_a, ram_rdata_a;
  logic       ack0_b, ack1_b, busy_b, ram_o_b, ram_oe_b, ram_wdrive_b;
  logic [1:0] gnt_b;
  logic [7:0] rdata0_b, rdata1_b, ram_addr_b, ram_wdata_b, ram_rdata_b;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_a), .rdata0(rdata0_a),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_a), .rdata1(rdata1_a),
    .gnt(gnt_a), .busy(busy_a), .ram_addr(ram_addr_a), .ram_o(ram_o_a), .ram_oe(ram_oe_a),
    .ram_wdata(ram_wdata_a), .ram_wdrive(ram_wdrive_a), .ram_rdata(ram_rdata_a));

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0_b), .rdata0(rdata0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1_b), .rdata1(rdata1_b),
    .gnt(gnt_b), .busy(busy_b), .ram_addr(ram_addr_b), .ram_o(ram_o_b), .ram_oe(ram_oe_b),
    .ram_wdata(ram_wdata_b), .ram_wdrive(ram_wdrive_b), .ram_rdata(ram_rdata_b));

  // Behavioural single-port RAMs: write on strobe, else load the read buffer.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] rbuf_a, rbuf_b;
  always @(posedge clk) begin
    if (ram_o_a) mem_a[ram_addr_a] <= ram_wdata_a;
    else         rbuf_a <= mem_a[ram_addr_a];
    if (ram_o_b) mem_b[ram_addr_b] <= ram_wdata_b;
    else         rbuf_b <= mem_b[ram_addr_b];
  end
  assign ram_rdata_a = ram_oe_a ? rbuf_a : 8'h00;
  assign ram_rdata_b = ram_oe_b ? rbuf_b : 8'h00;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] ref_mem [256];
  logic [7:0] ref_rd [2];
  bit         ref_last;
  int         known_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("inv_o_oe", {31'd0, ram_o_a & ram_oe_a}, 32'd0);
      chk("inv_drive", {31'd0, ram_wdrive_a & ~ram_o_a}, 32'd0);
    end
  end

  // Entered and left at an IDLE negedge with the requests already applied.
  task automatic txn(input bit drop, input bit scr);
    bit         r0, r1, win, fwin, wwe;
    logic [7:0] wad, wdt;
    r0 = req0; r1 = req1;
    win  = (r0 && r1) ? ~ref_last : r1;
    fwin = (r0 && r1) ? 1'b0 : r1;
    ref_last = win;
    wwe = win ? we1 : we0;
    wad = win ? addr1 : addr0;
    wdt = win ? wdata1 : wdata0;
    chk("idle_gnt", {30'd0, gnt_a}, 32'd0);
    chk("idle_busy", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    if (scr) begin
      addr0 = 8'($urandom); wdata0 = 8'($urandom);
      addr1 = 8'($urandom); wdata1 = 8'($urandom);
    end
    chk("gnt_rr", {30'd0, gnt_a}, {30'd0, oh(win)});
    chk("gnt_fp", {30'd0, gnt_b}, {30'd0, oh(fwin)});
    chk("busy", {31'd0, busy_a}, 32'd1);
    chk("ram_addr", {24'd0, ram_addr_a}, {24'd0, wad});
    chk("ram_o", {31'd0, ram_o_a}, {31'd0, wwe});
    chk("ram_oe1", {31'd0, ram_oe_a}, 32'd0);
    chk("ram_wdrive", {31'd0, ram_wdrive_a}, {31'd0, wwe});
    if (wwe) begin
      chk("ram_wdata", {24'd0, ram_wdata_a}, {24'd0, wdt});
      ref_mem[wad] = wdt;
      known_q.push_back(int'(wad));
    end else begin
      @(negedge clk);
      chk("rd_oe", {31'd0, ram_oe_a}, 32'd1);
      chk("rd_addr", {24'd0, ram_addr_a}, {24'd0, wad});
      chk("rd_drive", {31'd0, ram_wdrive_a}, 32'd0);
      chk("rd_noack", {30'd0, ack1_a, ack0_a}, 32'd0);
      ref_rd[win] = ref_mem[wad];
    end
    @(negedge clk);
    chk("ack_rr", {30'd0, ack1_a, ack0_a}, {30'd0, oh(win)});
    chk("ack_fp", {30'd0, ack1_b, ack0_b}, {30'd0, oh(fwin)});
    chk("resp_gnt", {30'd0, gnt_a}, {30'd0, oh(win)});
    chk("resp_bus", {22'd0, ram_addr_a, ram_o_a, ram_oe_a}, 32'd0);
    chk("rdata0", {24'd0, rdata0_a}, {24'd0, ref_rd[0]});
    chk("rdata1", {24'd0, rdata1_a}, {24'd0, ref_rd[1]});
    if (drop) begin
      if (win) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    @(negedge clk);
    chk("ack_pulse", {30'd0, ack1_a, ack0_a}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    ref_last = 1'b1; ref_rd[0] = 0; ref_rd[1] = 0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_gnt", {30'd0, gnt_a}, 32'd0);
    chk("rst_acks", {30'd0, ack1_a, ack0_a}, 32'd0);
    chk("rst_bus", {14'd0, ram_addr_a, ram_wdata_a, ram_o_a, ram_oe_a}, 32'd0);
    chk("rst_rdata", {16'd0, rdata1_a, rdata0_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Port 0 write, then port 1 reads it back.
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'hA5;
    txn(1, 0);
    req1 = 1; we1 = 0; addr1 = 8'h10;
    txn(1, 0);

    // Both held: round-robin alternates, fixed-priority stays on port 0.
    req0 = 1; we0 = 1; addr0 = 8'h01; wdata0 = 8'($urandom);
    req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'($urandom);
    for (int i = 0; i < 4; i++) txn(0, 0);
    txn(1, 0);
    txn(1, 0);

    // Reset during WR must suppress both the write and the ack.
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h33;
    txn(1, 0);
    req0 = 1; we0 = 1; addr0 = 8'h20; wdata0 = 8'h5A;
    @(negedge clk);
    chk("abort_wr", {31'd0, ram_o_a}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_o", {31'd0, ram_o_a}, 32'd0);
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    req0 = 0;
    @(negedge clk);
    chk("abort_ack", {30'd0, ack1_a, ack0_a}, 32'd0);
    rst = 1'b0;
    ref_last = 1'b1; ref_rd[0] = 0; ref_rd[1] = 0;
    @(negedge clk);
    req1 = 1; we1 = 0; addr1 = 8'h20;
    txn(1, 0);

    // Inputs scrambled after grant; top address round-trip.
    req0 = 1; we0 = 1; addr0 = 8'hFF; wdata0 = 8'hC3;
    txn(1, 1);
    req0 = 1; we0 = 0; addr0 = 8'hFF;
    txn(1, 1);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req0 = 1; we0 = 1; addr0 = 8'($urandom); wdata0 = 8'($urandom);
        req1 = 1; we1 = 1; addr1 = 8'($urandom); wdata1 = 8'($urandom);
        txn(1, 0);
        txn(1, 0);
      end else begin
        bit p;
        bit w;
        logic [7:0] a;
        p = 1'($urandom);
        w = 1'($urandom);
        a = w ? 8'($urandom) : 8'(known_q[$urandom_range(0, known_q.size() - 1)]);
        if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = 8'($urandom); end
        else   begin req0 = 1; we0 = w; addr0 = a; wdata0 = 8'($urandom); end
        txn(1, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
